// File: rtl/frame_resync_pkg.sv
// ============================================================================
// frame_resync_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the frame resynchronisation controller: the FSM state
// encoding, default parameter values, the divider counter width and a helper
// used to range-check the cycle parameters at elaboration time.
//
// Contents:
//   state_e             - controller phase (IDLE, DRAIN, PULSE, HOLD)
//   DEF_*               - default parameter values for the controller
//   DIV_W               - width of the end-of-packet divider counter
//   cycleParamOk()      - true when a cycle count lies in minVal..2^cntW
// ============================================================================
package frame_resync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int DEF_WAIT_CYCLES  = 7;
   localparam int DEF_RESET_CYCLES = 1;
   localparam int DEF_HOLD_CYCLES  = 5;
   localparam int DEF_FRAME_DIV    = 1;
   localparam int DEF_CNT_W        = 8;
   localparam int DEF_FCNT_W       = 16;

   // The divider only ever has to reach 254, so eight bits always suffice.
   localparam int DIV_W            = 8;

   // A phase of N cycles is timed by a counter running 0..N-1, so the largest
   // legal N for a cntW-bit counter is 2^cntW.
   function automatic bit cycleParamOk(input int value, input int minVal, input int cntW);
      return (value >= minVal) && (value <= (1 << cntW));
   endfunction

endpackage

// File: rtl/frame_resync_ctrl_if.sv
// ============================================================================
// frame_resync_ctrl_if
// ----------------------------------------------------------------------------
// Bundles the stream handshake, control requests and status outputs of the
// frame resynchronisation controller. Clock and reset are kept outside.
//
// Signals:
//   enable              - arms end-of-packet triggered resync
//   stream_valid        - upstream beat valid
//   stream_endofpacket  - beat is the last of a frame
//   resync_req          - single-cycle software resync request
//   stream_ready        - controller accepts beats (IDLE only)
//   video_stream_reset  - active-low reset to the downstream video pipeline
//   busy                - controller is in a resync sequence
//   frame_count         - accepted end-of-packet count
//
// Modports:
//   master - the stream source / software side (drives requests)
//   slave  - the controller itself
// ============================================================================
interface frame_resync_ctrl_if
   import frame_resync_pkg::*;
#(
   parameter int FCNT_W = DEF_FCNT_W
);

   logic              enable;
   logic              stream_valid;
   logic              stream_endofpacket;
   logic              resync_req;
   logic              stream_ready;
   logic              video_stream_reset;
   logic              busy;
   logic [FCNT_W-1:0] frame_count;

   modport master (
      output enable,
      output stream_valid,
      output stream_endofpacket,
      output resync_req,
      input  stream_ready,
      input  video_stream_reset,
      input  busy,
      input  frame_count
   );

   modport slave (
      input  enable,
      input  stream_valid,
      input  stream_endofpacket,
      input  resync_req,
      output stream_ready,
      output video_stream_reset,
      output busy,
      output frame_count
   );

endinterface

// File: rtl/frame_resync_timer.sv
// ============================================================================
// frame_resync_timer
// ----------------------------------------------------------------------------
// Phase timer for the resync controller. A load captures the length of the
// phase that is about to start and clears the counter; the counter then runs
// 0..limit-1 and stops there, raising done_o on the final cycle of the phase.
// The counter never wraps.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   load_i   in   start a new phase (clears the counter)
//   limit_i  in   length of the new phase in cycles (1..2^CNT_W)
//   done_o   out  high during the last cycle of the current phase
// ============================================================================
module frame_resync_timer
   import frame_resync_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W:0]   limit_i,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] last_q;
   logic [CNT_W:0]   limitMinusOne;
   logic [CNT_W-1:0] lastIndex;

   // The counter compares against limit-1, which always fits in CNT_W bits
   // because the limit is at most 2^CNT_W. A zero limit is never loaded by
   // the controller, but it is clamped so the stored index stays sane.
   always_comb begin
      limitMinusOne = limit_i - (CNT_W+1)'(1);
      lastIndex     = limitMinusOne[CNT_W-1:0];
      if (limit_i == '0) begin
         lastIndex = '0;
      end
   end

   // Load restarts the phase from zero; otherwise the counter advances until
   // it reaches the stored final index and parks there.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         last_q  <= '0;
      end else if (load_i) begin
         count_q <= '0;
         last_q  <= lastIndex;
      end else if (!done_o) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign done_o = (count_q == last_q);

endmodule

// File: rtl/frame_resync_ctrl.sv
// ============================================================================
// frame_resync_ctrl
// ----------------------------------------------------------------------------
// Frame resynchronisation controller. Counts accepted end-of-packet beats and,
// on every FRAME_DIV-th one while enabled (or on a software request), runs a
// resync sequence: stall the stream for WAIT_CYCLES (DRAIN), drive the
// active-low downstream reset for RESET_CYCLES (PULSE), then keep the stream
// stalled for HOLD_CYCLES (HOLD) before accepting data again (IDLE).
// Software requests that arrive mid-sequence are remembered and replayed once.
//
// Ports:
//   clk    in     clock, rising edge
//   reset  in     synchronous active-high reset
//   bus    slave  stream handshake, requests and status (see interface)
// ============================================================================
module frame_resync_ctrl
   import frame_resync_pkg::*;
#(
   parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int FRAME_DIV    = DEF_FRAME_DIV,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int FCNT_W       = DEF_FCNT_W
) (
   input  logic                clk,
   input  logic                reset,
   frame_resync_ctrl_if.slave  bus
);

   // Refuse to elaborate with parameters the timer or divider cannot honour.
   if (CNT_W < 1 || CNT_W > 30) begin : gBadCntW
      $error("frame_resync_ctrl: CNT_W must be 1..30");
   end
   if (FCNT_W < 1) begin : gBadFcntW
      $error("frame_resync_ctrl: FCNT_W must be at least 1");
   end
   if (!cycleParamOk(WAIT_CYCLES, 1, CNT_W)) begin : gBadWait
      $error("frame_resync_ctrl: WAIT_CYCLES must be 1..2^CNT_W");
   end
   if (!cycleParamOk(RESET_CYCLES, 1, CNT_W)) begin : gBadReset
      $error("frame_resync_ctrl: RESET_CYCLES must be 1..2^CNT_W");
   end
   if (!cycleParamOk(HOLD_CYCLES, 0, CNT_W)) begin : gBadHold
      $error("frame_resync_ctrl: HOLD_CYCLES must be 0..2^CNT_W");
   end
   if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : gBadDiv
      $error("frame_resync_ctrl: FRAME_DIV must be 1..255");
   end

   localparam logic [CNT_W:0] WAIT_LIM  = (CNT_W+1)'(WAIT_CYCLES);
   localparam logic [CNT_W:0] RESET_LIM = (CNT_W+1)'(RESET_CYCLES);
   localparam logic [CNT_W:0] HOLD_LIM  = (CNT_W+1)'(HOLD_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   state_e            state_q;
   state_e            state_d;
   logic              ready_q;
   logic              ready_d;
   logic              videoResetN_q;
   logic              videoResetN_d;
   logic              busy_q;
   logic              busy_d;
   logic              pending_q;
   logic              pending_d;
   logic [DIV_W-1:0]  divCnt_q;
   logic [DIV_W-1:0]  divCnt_d;
   logic [FCNT_W-1:0] frameCount_q;
   logic [FCNT_W-1:0] frameCount_d;

   logic              eopAccepted;
   logic              eopTrigger;
   logic              startSeq;
   logic              timerLoad;
   logic [CNT_W:0]    timerLimit;
   logic              timerDone;

   // A beat is only accepted while we advertise ready, which happens in IDLE
   // only, so any end-of-packet seen mid-sequence is dropped here. The divider
   // reaching its last value on an accepted end-of-packet is the trigger, and
   // a pending software request also counts as a reason to start.
   always_comb begin
      eopAccepted = bus.stream_valid & bus.stream_endofpacket & ready_q;
      eopTrigger  = eopAccepted & bus.enable & (divCnt_q == DIV_LAST);
      startSeq    = eopTrigger | bus.resync_req | pending_q;
   end

   // Bookkeeping for the frame counter, divider and pending request. The
   // divider is held at zero whenever enable is low so re-arming always starts
   // a fresh count. A request made while busy is folded into a single pending
   // flag; IDLE always consumes it because IDLE starts a sequence on it.
   always_comb begin
      frameCount_d = frameCount_q;
      if (eopAccepted) begin
         frameCount_d = frameCount_q + FCNT_W'(1);
      end

      divCnt_d = divCnt_q;
      if (!bus.enable || eopTrigger) begin
         divCnt_d = '0;
      end else if (eopAccepted) begin
         divCnt_d = divCnt_q + DIV_W'(1);
      end

      pending_d = 1'b0;
      if (state_q != ST_IDLE) begin
         pending_d = pending_q | bus.resync_req;
      end
   end

   // Next-state logic. Every phase change reloads the timer with the length
   // of the phase being entered; the PULSE exit skips HOLD entirely when no
   // recovery time is configured.
   always_comb begin
      state_d    = state_q;
      timerLoad  = 1'b0;
      timerLimit = WAIT_LIM;
      case (state_q)
         ST_IDLE: begin
            if (startSeq) begin
               state_d    = ST_DRAIN;
               timerLoad  = 1'b1;
               timerLimit = WAIT_LIM;
            end
         end
         ST_DRAIN: begin
            if (timerDone) begin
               state_d    = ST_PULSE;
               timerLoad  = 1'b1;
               timerLimit = RESET_LIM;
            end
         end
         ST_PULSE: begin
            if (timerDone) begin
               if (HOLD_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_HOLD;
                  timerLoad  = 1'b1;
                  timerLimit = HOLD_LIM;
               end
            end
         end
         ST_HOLD: begin
            if (timerDone) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered in
   // the same edge as the state itself and always match the current phase.
   always_comb begin
      ready_d       = (state_d == ST_IDLE);
      videoResetN_d = (state_d != ST_PULSE);
      busy_d        = (state_d != ST_IDLE);
   end

   // State and output registers. Reset wins over every input, including a
   // software request arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b1;
         videoResetN_q <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         videoResetN_q <= videoResetN_d;
         busy_q        <= busy_d;
      end
   end

   // Frame counter, divider and pending flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         frameCount_q <= '0;
         divCnt_q     <= '0;
         pending_q    <= 1'b0;
      end else begin
         frameCount_q <= frameCount_d;
         divCnt_q     <= divCnt_d;
         pending_q    <= pending_d;
      end
   end

   frame_resync_timer #(
      .CNT_W   (CNT_W)
   ) uTimer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (timerLoad),
      .limit_i (timerLimit),
      .done_o  (timerDone)
   );

   assign bus.stream_ready       = ready_q;
   assign bus.video_stream_reset = videoResetN_q;
   assign bus.busy               = busy_q;
   assign bus.frame_count        = frameCount_q;

endmodule

// File: tb/tb_frame_resync_ctrl.sv
// ============================================================================
// tb_frame_resync_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for frame_resync_ctrl. Three controllers run side by side:
//   A - default parameters
//   B - FRAME_DIV = 3
//   C - RESET_CYCLES = 3, HOLD_CYCLES = 0
// Stimulus threads push the hand-computed expected outputs for a given cycle
// into a queue; a monitor on the falling edge pops whatever is due and
// compares it against the controller outputs.
// ============================================================================
module tb_frame_resync_ctrl;

   typedef struct {
      int    dut;
      int    cyc;
      logic  rdy;
      logic  vrstN;
      logic  bsy;
      int    cnt;
      string name;
   } exp_t;

   logic clk;
   logic rstA;
   logic rstB;
   logic rstC;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   exp_t sbQ[$];

   frame_resync_ctrl_if #(.FCNT_W(16)) ifA ();
   frame_resync_ctrl_if #(.FCNT_W(16)) ifB ();
   frame_resync_ctrl_if #(.FCNT_W(16)) ifC ();

   frame_resync_ctrl dutA (
      .clk   (clk),
      .reset (rstA),
      .bus   (ifA)
   );

   frame_resync_ctrl #(
      .FRAME_DIV (3)
   ) dutB (
      .clk   (clk),
      .reset (rstB),
      .bus   (ifB)
   );

   frame_resync_ctrl #(
      .RESET_CYCLES (3),
      .HOLD_CYCLES  (0)
   ) dutC (
      .clk   (clk),
      .reset (rstC),
      .bus   (ifC)
   );

   // Free-running clock and cycle index; cycle N is the period after the Nth
   // rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic waitFor(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one controller's inputs for cycle c onward.
   task automatic applyStimulus(input int d, input int c, input logic en,
                                input logic v, input logic e, input logic r,
                                input logic rs);
      waitFor(c);
      case (d)
         0: begin
            ifA.enable = en; ifA.stream_valid = v; ifA.stream_endofpacket = e;
            ifA.resync_req = r; rstA = rs;
         end
         1: begin
            ifB.enable = en; ifB.stream_valid = v; ifB.stream_endofpacket = e;
            ifB.resync_req = r; rstB = rs;
         end
         default: begin
            ifC.enable = en; ifC.stream_valid = v; ifC.stream_endofpacket = e;
            ifC.resync_req = r; rstC = rs;
         end
      endcase
   endtask

   task automatic eopPulse(input int d, input int c, input logic en);
      applyStimulus(d, c, en, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(d, c + 1, en, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expectAt(input int d, input int c, input logic rdy,
                           input logic vrstN, input logic bsy, input int cnt,
                           input string name);
      exp_t e;
      e.dut = d; e.cyc = c; e.rdy = rdy; e.vrstN = vrstN; e.bsy = bsy;
      e.cnt = cnt; e.name = name;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic aR, aV, aB;
      int   aC;
      case (e.dut)
         0: begin
            aR = ifA.stream_ready; aV = ifA.video_stream_reset;
            aB = ifA.busy; aC = int'(ifA.frame_count);
         end
         1: begin
            aR = ifB.stream_ready; aV = ifB.video_stream_reset;
            aB = ifB.busy; aC = int'(ifB.frame_count);
         end
         default: begin
            aR = ifC.stream_ready; aV = ifC.video_stream_reset;
            aB = ifC.busy; aC = int'(ifC.frame_count);
         end
      endcase
      checks++;
      if (aR === e.rdy && aV === e.vrstN && aB === e.bsy && aC == e.cnt) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s @cycle %0d: got ready=%b vrst_n=%b busy=%b count=%0d, want ready=%b vrst_n=%b busy=%b count=%0d",
                  e.name, cyc, aR, aV, aB, aC, e.rdy, e.vrstN, e.bsy, e.cnt);
      end
   endtask

   // Monitor: on each falling edge, compare every expectation due this cycle.
   always @(negedge clk) begin
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
         if (sbQ[i].cyc == cyc) begin
            checkOutput(sbQ[i]);
            sbQ.delete(i);
         end
      end
   end

   initial begin
      rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
      ifA.enable = 1'b0; ifA.stream_valid = 1'b0; ifA.stream_endofpacket = 1'b0; ifA.resync_req = 1'b0;
      ifB.enable = 1'b0; ifB.stream_valid = 1'b0; ifB.stream_endofpacket = 1'b0; ifB.resync_req = 1'b0;
      ifC.enable = 1'b0; ifC.stream_valid = 1'b0; ifC.stream_endofpacket = 1'b0; ifC.resync_req = 1'b0;

      fork
         // Controller A: default timing, software requests, reset mid-pulse.
         begin
            applyStimulus(0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expectAt(0, 3, 1, 1, 0, 0, "A reset state");
            applyStimulus(0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            expectAt(0, 6, 1, 1, 0, 0, "A eop without valid");
            applyStimulus(0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            eopPulse(0, 10, 1'b1);
            expectAt(0, 11, 0, 1, 1, 1, "A drain first");
            expectAt(0, 17, 0, 1, 1, 1, "A drain last");
            expectAt(0, 18, 0, 0, 1, 1, "A pulse");
            expectAt(0, 19, 0, 1, 1, 1, "A hold first");
            expectAt(0, 23, 0, 1, 1, 1, "A hold last");
            expectAt(0, 24, 1, 1, 0, 1, "A back to idle");
            eopPulse(0, 12, 1'b1);
            applyStimulus(0, 28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(0, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expectAt(0, 31, 0, 1, 1, 1, "A resync with enable low");
            applyStimulus(0, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expectAt(0, 44, 1, 1, 0, 1, "A idle before pending");
            expectAt(0, 45, 0, 1, 1, 1, "A pending starts");
            expectAt(0, 52, 0, 0, 1, 1, "A pending pulse");
            expectAt(0, 58, 1, 1, 0, 1, "A pending done");
            expectAt(0, 59, 1, 1, 0, 1, "A no third sequence");
            applyStimulus(0, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(0, 33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(0, 34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(0, 35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            eopPulse(0, 60, 1'b0);
            expectAt(0, 61, 1, 1, 0, 2, "A eop counted enable low");
            applyStimulus(0, 64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(0, 70, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            expectAt(0, 71, 0, 1, 1, 2, "A drain before reset");
            applyStimulus(0, 71, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(0, 78, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            expectAt(0, 78, 0, 0, 1, 2, "A pulse before reset");
            expectAt(0, 79, 1, 1, 0, 0, "A reset during pulse");
            applyStimulus(0, 79, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expectAt(0, 81, 1, 1, 0, 0, "A no pending after reset");
         end

         // Controller B: divide-by-three, simultaneous triggers, enable drop.
         begin
            applyStimulus(1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expectAt(1, 3, 1, 1, 0, 0, "B reset state");
            eopPulse(1, 5, 1'b1);
            expectAt(1, 6, 1, 1, 0, 1, "B div one of three");
            eopPulse(1, 7, 1'b1);
            expectAt(1, 8, 1, 1, 0, 2, "B div two of three");
            eopPulse(1, 9, 1'b1);
            expectAt(1, 10, 0, 1, 1, 3, "B third eop triggers");
            expectAt(1, 23, 1, 1, 0, 3, "B idle again");
            eopPulse(1, 25, 1'b1);
            expectAt(1, 26, 1, 1, 0, 4, "B div one again");
            eopPulse(1, 27, 1'b1);
            applyStimulus(1, 29, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            expectAt(1, 30, 0, 1, 1, 6, "B eop plus request");
            expectAt(1, 43, 1, 1, 0, 6, "B single sequence");
            expectAt(1, 44, 1, 1, 0, 6, "B no pending left");
            applyStimulus(1, 30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            eopPulse(1, 45, 1'b1);
            expectAt(1, 46, 1, 1, 0, 7, "B div cleared one");
            eopPulse(1, 47, 1'b1);
            expectAt(1, 48, 1, 1, 0, 8, "B div cleared two");
            eopPulse(1, 49, 1'b1);
            expectAt(1, 50, 0, 1, 1, 9, "B div cleared three");
            eopPulse(1, 65, 1'b1);
            expectAt(1, 66, 1, 1, 0, 10, "B div one before drop");
            applyStimulus(1, 66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1, 67, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            eopPulse(1, 69, 1'b1);
            eopPulse(1, 71, 1'b1);
            expectAt(1, 72, 1, 1, 0, 12, "B enable drop cleared div");
            eopPulse(1, 73, 1'b1);
            expectAt(1, 74, 0, 1, 1, 13, "B trigger after re-arm");
         end

         // Controller C: three-cycle pulse and no hold phase.
         begin
            applyStimulus(2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expectAt(2, 3, 1, 1, 0, 0, "C reset state");
            applyStimulus(2, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            expectAt(2, 6, 0, 1, 1, 0, "C drain first");
            expectAt(2, 12, 0, 1, 1, 0, "C drain last");
            expectAt(2, 13, 0, 0, 1, 0, "C pulse first");
            expectAt(2, 15, 0, 0, 1, 0, "C pulse third");
            expectAt(2, 16, 1, 1, 0, 0, "C straight to idle");
            applyStimulus(2, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      join

      waitFor(85);
      foreach (sbQ[i]) begin
         checks++;
         $display("[TB] FAIL %s: expectation for cycle %0d never compared, want ready=%b",
                  sbQ[i].name, sbQ[i].cyc, sbQ[i].rdy);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
